// File: rtl/cbdcer_ld_pkg.sv
// cbdcer_ld_pkg
//   Shared defaults for the loadable down-counter/timer block.
//   No ports. Provides the default counter width and option settings that the
//   interface and the top-level module use as parameter defaults.
package cbdcer_ld_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam bit DEF_TMR         = 1'b0;
  localparam bit DEF_AUTO_RELOAD = 1'b0;

endpackage

// File: rtl/cbdcer_ld_if.sv
// cbdcer_ld_if
//   Control/status bundle of the down-counter/timer.
//   Signals:
//     ce      count enable (master -> slave)
//     load    load strobe (master -> slave)
//     ld_val  start / reload value, WIDTH bits (master -> slave)
//     q       current count, WIDTH bits (slave -> master)
//     tc      one-cycle terminal-count pulse (slave -> master)
//     busy    counter running (slave -> master)
//   master: the controlling logic; slave: the counter itself.
interface cbdcer_ld_if
  import cbdcer_ld_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             ce;
  logic             load;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  modport master (
    output ce, load, ld_val,
    input  q, tc, busy
  );

  modport slave (
    input  ce, load, ld_val,
    output q, tc, busy
  );

endinterface

// File: rtl/cbdcer_ld_vote.sv
// cbdcer_ld_vote
//   Width-generic bitwise 2-of-3 majority voter.
//   Ports:
//     a, b, c  in   WIDTH  the three redundant copies
//     y        out  WIDTH  bitwise majority of a, b, c
module cbdcer_ld_vote #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/cbdcer_ld.sv
// cbdcer_ld
//   Loadable synchronous down-counter/timer with clock enable, terminal-count
//   pulse, optional auto-reload and optional triple-modular redundancy.
//   Ports:
//     clk   in   rising-edge clock
//     srst  in   synchronous reset, active-high (overrides load and ce)
//     bus   slave modport of cbdcer_ld_if (ce, load, ld_val in; q, tc, busy out)
//   Parameters:
//     WIDTH        counter / load-value width
//     TMR          1 = triplicated state, voted every cycle
//     AUTO_RELOAD  1 = reload the last loaded value on terminal count
module cbdcer_ld
  import cbdcer_ld_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter bit TMR         = DEF_TMR,
  parameter bit AUTO_RELOAD = DEF_AUTO_RELOAD
) (
  input  logic          clk,
  input  logic          srst,
  cbdcer_ld_if.slave    bus
);

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rld;
    logic             tc;
    logic             busy;
  } state_t;

  // Next state with priority load > ce > hold; tc is a pulse so it clears
  // unless this very edge consumes the last count.
  function automatic state_t next_state(
    input state_t           cur_st,
    input logic             ce,
    input logic             load,
    input logic [WIDTH-1:0] ld_val
  );
    state_t nxt_st;
    nxt_st    = cur_st;
    nxt_st.tc = 1'b0;
    if (load) begin
      nxt_st.cnt  = ld_val;
      nxt_st.rld  = ld_val;
      nxt_st.busy = (ld_val != '0);
    end else if (ce && (cur_st.cnt != '0)) begin
      if (cur_st.cnt == WIDTH'(1)) begin
        nxt_st.tc = 1'b1;
        if (AUTO_RELOAD) begin
          nxt_st.cnt  = cur_st.rld;
          nxt_st.busy = 1'b1;
        end else begin
          nxt_st.cnt  = '0;
          nxt_st.busy = 1'b0;
        end
      end else begin
        nxt_st.cnt = cur_st.cnt - WIDTH'(1);
      end
    end
    return nxt_st;
  endfunction

  state_t cur;
  state_t nxt;

  assign nxt = next_state(cur, bus.ce, bus.load, bus.ld_val);

  generate
    if (TMR) begin : g_tmr
      logic [WIDTH-1:0] cnt_a, cnt_b, cnt_c;
      logic [WIDTH-1:0] rld_a, rld_b, rld_c;
      logic [1:0]       flg_a, flg_b, flg_c;
      logic [WIDTH-1:0] cnt_v;
      logic [WIDTH-1:0] rld_v;
      logic [1:0]       flg_v;

      // All three copies load the same voted next state, so a single upset
      // copy is overwritten on the following edge.
      always_ff @(posedge clk) begin
        if (srst) begin
          cnt_a <= '0;  cnt_b <= '0;  cnt_c <= '0;
          rld_a <= '0;  rld_b <= '0;  rld_c <= '0;
          flg_a <= '0;  flg_b <= '0;  flg_c <= '0;
        end else begin
          cnt_a <= nxt.cnt;  cnt_b <= nxt.cnt;  cnt_c <= nxt.cnt;
          rld_a <= nxt.rld;  rld_b <= nxt.rld;  rld_c <= nxt.rld;
          flg_a <= {nxt.tc, nxt.busy};
          flg_b <= {nxt.tc, nxt.busy};
          flg_c <= {nxt.tc, nxt.busy};
        end
      end

      cbdcer_ld_vote #(.WIDTH(WIDTH)) u_vote_cnt (
        .a(cnt_a), .b(cnt_b), .c(cnt_c), .y(cnt_v)
      );
      cbdcer_ld_vote #(.WIDTH(WIDTH)) u_vote_rld (
        .a(rld_a), .b(rld_b), .c(rld_c), .y(rld_v)
      );
      cbdcer_ld_vote #(.WIDTH(2)) u_vote_flg (
        .a(flg_a), .b(flg_b), .c(flg_c), .y(flg_v)
      );

      assign cur.cnt  = cnt_v;
      assign cur.rld  = rld_v;
      assign cur.tc   = flg_v[1];
      assign cur.busy = flg_v[0];
    end else begin : g_notmr
      state_t st;

      always_ff @(posedge clk) begin
        if (srst) begin
          st <= '0;
        end else begin
          st <= nxt;
        end
      end

      assign cur = st;
    end
  endgenerate

  assign bus.q    = cur.cnt;
  assign bus.tc   = cur.tc;
  assign bus.busy = cur.busy;

endmodule

// File: tb/tb_cbdcer_ld.sv
// tb_cbdcer_ld
//   Bench for cbdcer_ld. Four instances share one stimulus stream:
//     d0 TMR=0 AUTO_RELOAD=0, d1 TMR=0 AUTO_RELOAD=1,
//     d2 TMR=1 AUTO_RELOAD=0, d3 TMR=1 AUTO_RELOAD=1.
//   A reference timer model (one per reload mode) is compared against every
//   instance on each falling edge; directed sequences add literal checks.
module tb_cbdcer_ld;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         srst;
  logic         ce;
  logic         load;
  logic [W-1:0] ld_val;
  logic         chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cbdcer_ld_if #(.WIDTH(W)) b0 ();
  cbdcer_ld_if #(.WIDTH(W)) b1 ();
  cbdcer_ld_if #(.WIDTH(W)) b2 ();
  cbdcer_ld_if #(.WIDTH(W)) b3 ();

  assign b0.ce = ce;  assign b0.load = load;  assign b0.ld_val = ld_val;
  assign b1.ce = ce;  assign b1.load = load;  assign b1.ld_val = ld_val;
  assign b2.ce = ce;  assign b2.load = load;  assign b2.ld_val = ld_val;
  assign b3.ce = ce;  assign b3.load = load;  assign b3.ld_val = ld_val;

  cbdcer_ld #(.WIDTH(W), .TMR(1'b0), .AUTO_RELOAD(1'b0)) d0 (.clk(clk), .srst(srst), .bus(b0));
  cbdcer_ld #(.WIDTH(W), .TMR(1'b0), .AUTO_RELOAD(1'b1)) d1 (.clk(clk), .srst(srst), .bus(b1));
  cbdcer_ld #(.WIDTH(W), .TMR(1'b1), .AUTO_RELOAD(1'b0)) d2 (.clk(clk), .srst(srst), .bus(b2));
  cbdcer_ld #(.WIDTH(W), .TMR(1'b1), .AUTO_RELOAD(1'b1)) d3 (.clk(clk), .srst(srst), .bus(b3));

  // Reference timer: index 0 stops at zero, index 1 auto-reloads.
  // busy is derived from the remaining count; tc marks an edge that
  // consumed the last remaining count.
  logic [W-1:0] m_q  [2];
  logic [W-1:0] m_rl [2];
  logic         m_tc [2];

  always @(posedge clk) begin
    for (int ar = 0; ar < 2; ar++) begin
      m_tc[ar] <= !srst && !load && ce && (m_q[ar] == W'(1));
      if (srst) begin
        m_q[ar]  <= '0;
        m_rl[ar] <= '0;
      end else if (load) begin
        m_q[ar]  <= ld_val;
        m_rl[ar] <= ld_val;
      end else if (ce && (m_q[ar] != '0)) begin
        if (m_q[ar] == W'(1)) m_q[ar] <= (ar == 1) ? m_rl[ar] : '0;
        else                  m_q[ar] <= m_q[ar] - W'(1);
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("d0.q",    b0.q,        m_q[0]);
      chk("d0.tc",   W'(b0.tc),   W'(m_tc[0]));
      chk("d0.busy", W'(b0.busy), W'(m_q[0] != '0));
      chk("d1.q",    b1.q,        m_q[1]);
      chk("d1.tc",   W'(b1.tc),   W'(m_tc[1]));
      chk("d1.busy", W'(b1.busy), W'(m_q[1] != '0));
      chk("d2.q",    b2.q,        m_q[0]);
      chk("d2.tc",   W'(b2.tc),   W'(m_tc[0]));
      chk("d2.busy", W'(b2.busy), W'(m_q[0] != '0));
      chk("d3.q",    b3.q,        m_q[1]);
      chk("d3.tc",   W'(b3.tc),   W'(m_tc[1]));
      chk("d3.busy", W'(b3.busy), W'(m_q[1] != '0));
    end
  end

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic cyc(input logic c, input logic l, input logic [W-1:0] v);
    ce     = c;
    load   = l;
    ld_val = v;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [W-1:0] q0, input logic tc0,
                     input logic bz0, input logic [W-1:0] q1, input logic tc1,
                     input logic bz1);
    chk({nm, " lit d0.q"},    b0.q,        q0);
    chk({nm, " lit d0.tc"},   W'(b0.tc),   W'(tc0));
    chk({nm, " lit d0.busy"}, W'(b0.busy), W'(bz0));
    chk({nm, " lit d1.q"},    b1.q,        q1);
    chk({nm, " lit d1.tc"},   W'(b1.tc),   W'(tc1));
    chk({nm, " lit d1.busy"}, W'(b1.busy), W'(bz1));
  endtask

  initial begin
    srst   = 1'b1;
    load   = 1'b1;
    ld_val = W'(5);
    ce     = 1'b1;
    repeat (2) @(negedge clk);
    lit("reset", 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    srst   = 1'b0;

    // One-shot from 3 (d1 reloads at the terminal edge).
    cyc(0, 1, 3);  lit("os load3", 3, 0, 1, 3, 0, 1);
    cyc(1, 0, 0);  lit("os q2",    2, 0, 1, 2, 0, 1);
    cyc(1, 0, 0);  lit("os q1",    1, 0, 1, 1, 0, 1);
    cyc(1, 0, 0);  lit("os q0",    0, 1, 0, 3, 1, 1);
    cyc(1, 0, 0);  lit("os hold",  0, 0, 0, 2, 0, 1);
    cyc(1, 0, 0);  lit("os hold2", 0, 0, 0, 1, 0, 1);

    // Gated CE from 4: decrement only on enabled edges.
    cyc(0, 1, 4);
    for (int i = 0; i < 8; i++) begin
      int k;
      k = i / 2 + 1;
      cyc((i % 2) == 0, 0, 0);
      if ((i % 2) == 0) begin
        chk("gated q",  b0.q,      W'(4 - k));
        chk("gated tc", W'(b0.tc), W'(k == 4));
      end else begin
        chk("gated q idle",  b0.q,      W'(4 - k));
        chk("gated tc idle", W'(b0.tc), '0);
      end
    end

    // Auto-reload with period 2.
    cyc(0, 1, 2);
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 0, 0);
      chk("ar q",    b1.q,        (k % 2) ? W'(1) : W'(2));
      chk("ar tc",   W'(b1.tc),   W'((k % 2) == 0));
      chk("ar busy", W'(b1.busy), W'(1));
    end

    // Load collisions.
    cyc(1, 1, 6);  lit("ld6 ce",   6, 0, 1, 6, 0, 1);
    cyc(0, 1, 0);  lit("ld0",      0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0);  lit("ld0 ce",   0, 0, 0, 0, 0, 0);
    cyc(0, 1, 2);
    cyc(1, 0, 0);  lit("pre rl",   1, 0, 1, 1, 0, 1);
    cyc(1, 1, 5);  lit("rl5 at1",  5, 0, 1, 5, 0, 1);

    // Maximum delay.
    cyc(0, 1, W'(15));
    repeat (14) cyc(1, 0, 0);
    lit("max q1", 1, 0, 1, 1, 0, 1);
    cyc(1, 0, 0);  lit("max tc", 0, 1, 0, 15, 1, 1);

    // Reset mid-count aborts without a terminal pulse.
    cyc(0, 1, 3);
    cyc(1, 0, 0);
    srst = 1'b1;
    cyc(1, 0, 0);  lit("abort", 0, 0, 0, 0, 0, 0);
    srst = 1'b0;
    cyc(1, 0, 0);  lit("abort2", 0, 0, 0, 0, 0, 0);

    // Upset one count copy in each TMR instance for one cycle.
    cyc(0, 1, 9);
    cyc(1, 0, 0);
    force d2.g_tmr.cnt_b = 4'hA;
    force d3.g_tmr.cnt_a = 4'h0;
    cyc(1, 0, 0);
    release d2.g_tmr.cnt_b;
    release d3.g_tmr.cnt_a;
    cyc(1, 0, 0);
    chk("scrub d2.cnt_b", d2.g_tmr.cnt_b, m_q[0]);
    chk("scrub d3.cnt_a", d3.g_tmr.cnt_a, m_q[1]);
    chk("scrub lit q",    b2.q,           W'(6));

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      srst = ($urandom_range(0, 49) == 0);
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, W'($urandom));
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
